// File: rtl/latch_writer_pkg.sv
// Shared definitions for the latch write sequencer: state encodings, default timing, helpers.
// The timing defaults are also used by the latch bank models.
package latch_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CLR    = 3'd4
    } state_e;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_NLATCH     = 6;
    localparam int DEF_AW         = 3;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_writer_cyc_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module cyc_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/latch_writer.sv
// Write-side sequencer for a bank of transparent latches: SETUP -> STROBE -> HOLD per write,
// plus a bank clear pulse. Every latch-facing output comes straight from a flop.
module latch_writer
    import latch_writer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NLATCH     = DEF_NLATCH,
    parameter int AW         = DEF_AW,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              nclr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr_req,
    output logic              bad_addr,
    output logic [WIDTH-1:0]  lat_d,
    output logic [NLATCH-1:0] lat_en,
    output logic              lat_nclr
);

    localparam int CW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
    localparam logic [AW:0] NLATCH_W = (AW + 1)'(NLATCH);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  lat_d_q, lat_d_d;
    logic [NLATCH-1:0] lat_en_q, lat_en_d;
    logic              wr_ready_q, wr_ready_d;
    logic              lat_nclr_q, lat_nclr_d;
    logic              bad_addr_q, bad_addr_d;
    logic              accept;
    logic              cnt_load;
    logic [CW-1:0]     cnt_load_val;
    logic              cnt_zero;

    cyc_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (nclr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d_d = lat_d_q;
        accept  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // wr_ready_q is low only on the first cycle after reset release.
                if (wr_ready_q) begin
                    if (clr_req) begin
                        state_d = ST_CLR;
                    end else if (wr_valid) begin
                        accept  = 1'b1;
                        addr_d  = wr_addr;
                        lat_d_d = wr_data;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP:  if (cnt_zero) state_d = ST_STROBE;
            ST_STROBE: if (cnt_zero) state_d = ST_HOLD;
            ST_HOLD:   if (cnt_zero) state_d = ST_IDLE;
            ST_CLR:    if (cnt_zero) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        cnt_load = (state_d != state_q);
        unique case (state_d)
            ST_SETUP:  cnt_load_val = CW'(SETUP_CYC - 1);
            ST_STROBE: cnt_load_val = CW'(STROBE_CYC - 1);
            ST_HOLD:   cnt_load_val = CW'(HOLD_CYC - 1);
            ST_CLR:    cnt_load_val = CW'(STROBE_CYC - 1);
            default:   cnt_load_val = '0;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it.
        lat_en_d = '0;
        if (state_d == ST_STROBE) begin
            for (int i = 0; i < NLATCH; i++)
                lat_en_d[i] = (addr_d == AW'(i));
        end
        wr_ready_d = (state_d == ST_IDLE);
        lat_nclr_d = (state_d != ST_CLR);
        bad_addr_d = accept && ({1'b0, wr_addr} >= NLATCH_W);
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            lat_d_q    <= '0;
            lat_en_q   <= '0;
            wr_ready_q <= 1'b0;
            lat_nclr_q <= 1'b0;
            bad_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lat_d_q    <= lat_d_d;
            lat_en_q   <= lat_en_d;
            wr_ready_q <= wr_ready_d;
            lat_nclr_q <= lat_nclr_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign lat_d    = lat_d_q;
    assign lat_en   = lat_en_q;
    assign lat_nclr = lat_nclr_q;
    assign bad_addr = bad_addr_q;

endmodule
